// File: rtl/sw_ctrl.sv
// Four-switch debouncer with press detection and display-mode selection.
// Raw switch levels are synchronised, debounced, and rising edges select the current mode.
module sw_ctrl #(
    parameter int DEB_CYCLES = 240000,
    parameter int CNT_W      = 18
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] sw_i,
    output logic [3:0] sw_o,
    output logic [3:0] press_o,
    output logic [1:0] mode_o,
    output logic       mode_chg_o
);

    localparam logic [CNT_W-1:0] DEB_MAX = CNT_W'(DEB_CYCLES - 1);

    logic [3:0]       sync1;
    logic [3:0]       sync2;
    logic [CNT_W-1:0] cnt [4];
    logic [3:0]       sw_nxt;
    logic [1:0]       low_idx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= sw_i;
            sync2 <= sync1;
        end
    end

    // A bit flips only after DEB_CYCLES consecutive mismatching edges.
    always_comb begin
        sw_nxt = sw_o;
        for (int i = 0; i < 4; i++) begin
            if (sync2[i] != sw_o[i] && cnt[i] == DEB_MAX)
                sw_nxt[i] = sync2[i];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++)
                cnt[i] <= '0;
            sw_o    <= '0;
            press_o <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (sync2[i] == sw_o[i] || cnt[i] == DEB_MAX)
                    cnt[i] <= '0;
                else
                    cnt[i] <= cnt[i] + CNT_W'(1);
            end
            sw_o    <= sw_nxt;
            press_o <= sw_nxt & ~sw_o;
        end
    end

    // Lowest pressed index wins when several switches rise together.
    always_comb begin
        low_idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (press_o[i])
                low_idx = 2'(i);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_o     <= 2'd0;
            mode_chg_o <= 1'b0;
        end else if (press_o != 4'd0) begin
            mode_o     <= low_idx;
            mode_chg_o <= (low_idx != mode_o);
        end else begin
            mode_chg_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sw_ctrl.sv
// Randomised scoreboard bench for sw_ctrl: a windowed reference model predicts
// every cycle's outputs and a negedge monitor compares them against the DUT.
module tb_sw_ctrl;

    localparam int DEB = 4;
    localparam int CW  = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] sw_i;
    logic [3:0] sw_o;
    logic [3:0] press_o;
    logic [1:0] mode_o;
    logic       mode_chg_o;

    int n_checks = 0;
    int n_fail   = 0;
    int dut_presses = 0;
    int exp_presses = 0;
    bit done = 1'b0;

    logic [10:0] exp_q[$];

    sw_ctrl #(.DEB_CYCLES(DEB), .CNT_W(CW)) dut (
        .clk        (clk),
        .rst        (rst),
        .sw_i       (sw_i),
        .sw_o       (sw_o),
        .press_o    (press_o),
        .mode_o     (mode_o),
        .mode_chg_o (mode_chg_o)
    );

    always #5 clk = ~clk;

    // Reference model: raw samples seen 2..DEB+1 edges ago form the window the
    // debouncer acts on; a bit flips when that whole window disagrees with it.
    logic [3:0] hist[$];
    logic [3:0] m_sw, m_press;
    logic [1:0] m_mode;
    logic       m_chg;

    task automatic model_clear();
        m_sw = '0; m_press = '0; m_mode = '0; m_chg = 1'b0;
        hist = {};
        for (int k = 0; k <= DEB; k++) hist.push_back(4'h0);
    endtask

    always @(posedge rst) model_clear();

    always @(posedge clk) begin
        logic [3:0] all_one, all_zero, flip, new_sw;
        int idx;
        if (rst) begin
            model_clear();
        end else begin
            all_one  = 4'hF;
            all_zero = 4'hF;
            for (int k = 1; k <= DEB; k++) begin
                all_one  = all_one & hist[k];
                all_zero = all_zero & ~hist[k];
            end
            flip   = (~m_sw & all_one) | (m_sw & all_zero);
            new_sw = m_sw ^ flip;
            if (m_press != 4'h0) begin
                idx = 0;
                while (!m_press[idx]) idx++;
                m_chg  = (2'(idx) != m_mode);
                m_mode = 2'(idx);
            end else begin
                m_chg = 1'b0;
            end
            m_press = new_sw & ~m_sw;
            m_sw    = new_sw;
            hist.push_front(sw_i);
            void'(hist.pop_back());
        end
        exp_q.push_back({m_sw, m_press, m_mode, m_chg});
    end

    // Monitor: one expected record per edge, compared half a cycle later.
    always @(negedge clk) begin
        logic [10:0] exp_v, act;
        if (!done) begin
            n_checks++;
            act = {sw_o, press_o, mode_o, mode_chg_o};
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL scoreboard_empty at %0t: got %h, no expected entry", $time, act);
            end else begin
                exp_v = exp_q.pop_front();
                if (rst) exp_v = '0;
                if (act !== exp_v) begin
                    n_fail++;
                    $display("FAIL outputs at %0t: got sw=%b press=%b mode=%0d chg=%b, expected sw=%b press=%b mode=%0d chg=%b",
                             $time, act[10:7], act[6:3], act[2:1], act[0],
                             exp_v[10:7], exp_v[6:3], exp_v[2:1], exp_v[0]);
                end
                dut_presses += $countones(press_o);
                exp_presses += $countones(exp_v[6:3]);
            end
        end
    end

    task automatic hold(input logic [3:0] v, input int n);
        sw_i = v;
        repeat (n) @(posedge clk);
        #2;
    endtask

    initial begin
        logic [3:0] v;
        int n;
        rst  = 1'b1;
        sw_i = 4'hF;
        repeat (5) @(posedge clk);
        #2;
        rst = 1'b0;
        hold(4'h0, 10);
        // single press, release, mode change, re-press of current mode
        hold(4'h1, 10);
        hold(4'h0, 10);
        hold(4'h4, 10);
        hold(4'h0, 10);
        hold(4'h4, 10);
        hold(4'h0, 10);
        // glitch shorter than the debounce window
        hold(4'h2, 3);
        hold(4'h0, 10);
        // simultaneous press
        hold(4'hA, 10);
        hold(4'h0, 10);
        // reset in the middle of a debounce
        hold(4'h8, 3);
        rst = 1'b1;
        hold(4'h8, 2);
        rst = 1'b0;
        hold(4'h8, 10);
        hold(4'h0, 10);
        // switch held through reset
        hold(4'h2, 2);
        rst = 1'b1;
        hold(4'h2, 4);
        rst = 1'b0;
        hold(4'h2, 10);
        // random levels with random dwell, bouncing included via short dwells
        repeat (150) begin
            v = 4'($urandom_range(0, 15));
            n = $urandom_range(1, 9);
            if ($urandom_range(0, 29) == 0) begin
                rst = 1'b1;
                hold(v, 1);
                rst = 1'b0;
            end
            hold(v, n);
        end
        hold(4'h0, 12);
        done = 1'b1;
        n_checks++;
        if (dut_presses != exp_presses) begin
            n_fail++;
            $display("FAIL press_count: got %0d, expected %0d", dut_presses, exp_presses);
        end
        n_checks++;
        if (exp_presses < 8) begin
            n_fail++;
            $display("FAIL press_activity: got %0d presses, expected at least 8", exp_presses);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
